tdm_demux: RTL and testbench

- Receive-side counterpart of the team's selector/mux datapath.
- Takes one time-multiplexed sample stream (one channel per valid beat, frame-aligned by a sync flag) and routes each sample to a registered per-channel output.
- Aligns to the frame, counts channels, strobes per-channel valid, flags frame completion and sync errors.
- Sits between a serial/TDM link and per-channel consumers.

---
 rtl/tdm_pkg.sv | 9 +
 rtl/tdm_chan_counter.sv | 24 ++
 rtl/tdm_demux.sv | 68 ++++++
 tb/tb_tdm_demux.sv | 93 +++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and defaults for the TDM mux/demux pair
package tdm_pkg;
  localparam int N_CH_DEF = 4;
  localparam int DW_DEF = 8;
  typedef enum logic {HUNT, LOCKED} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tdm_chan_counter.sv
// tdm_chan_counter: modulo-N_CH channel counter with load-to-1, clear and last flag
module tdm_chan_counter
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int CW = cnt_w(N_CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load1,
  input  logic          i_clear,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);
  logic [CW-1:0] r_cnt;
  assign o_cnt = r_cnt;
  assign o_last = r_cnt == CW'(N_CH - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) r_cnt <= '0;
    else if (i_load1) r_cnt <= CW'(1);
    else if (i_inc) r_cnt <= o_last ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: frame-aligned TDM receiver routing each beat to a registered channel slice
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [N_CH*DW-1:0] dout,
  output logic [N_CH-1:0]  dout_valid,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
);
  localparam int CW = cnt_w(N_CH);
  state_t r_state, w_next;
  logic [CW-1:0] w_cnt, w_ch;
  logic w_last, w_zero, w_sync, w_wr, w_inc, w_clear, w_err, w_done;
  logic [N_CH*DW-1:0] r_dout;
  logic [N_CH-1:0] r_dv;
  logic r_done, r_err;
  tdm_chan_counter #(.N_CH(N_CH), .CW(CW)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load1 (w_sync),
    .i_clear (w_clear),
    .i_inc   (w_inc),
    .o_cnt   (w_cnt),
    .o_last  (w_last)
  );
  // A qualified sync always restarts the frame at channel 0, from either state.
  always_comb begin
    w_sync = din_valid && frame_sync;
    w_zero = w_cnt == '0;
    w_inc = din_valid && !frame_sync && r_state == LOCKED && !w_zero;
    w_clear = din_valid && !frame_sync && r_state == LOCKED && w_zero;
    w_wr = w_sync || w_inc;
    w_ch = w_sync ? '0 : w_cnt;
    w_err = (w_sync && r_state == LOCKED && !w_zero) || w_clear;
    w_done = w_inc && w_last;
    w_next = w_sync ? LOCKED : w_clear ? HUNT : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_dout <= '0;
      r_dv <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dv <= w_wr ? N_CH'(1) << w_ch : '0;
      r_done <= w_done;
      r_err <= w_err;
      for (int k = 0; k < N_CH; k++)
        if (w_wr && w_ch == CW'(k)) r_dout[k*DW +: DW] <= din;
    end
  end
  assign dout = r_dout;
  assign dout_valid = r_dv;
  assign frame_done = r_done;
  assign sync_err = r_err;
  assign locked = r_state == LOCKED;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed-vector bench for tdm_demux with N_CH=4, DW=8
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] din = '0;
  logic din_valid = 1'b0;
  logic frame_sync = 1'b0;
  logic [31:0] dout;
  logic [3:0] dout_valid;
  logic frame_done, sync_err, locked;
  int n_cmp = 0;
  int n_bad = 0;
  tdm_demux #(.N_CH(4), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Apply one cycle of inputs, then check the registered response 1ns after the edge.
  task automatic step(input string tag, input logic r, input logic [7:0] d, input logic v,
                      input logic s, input logic [3:0] dv, input logic fd, input logic se,
                      input logic lk, input logic [31:0] dq);
    rst_n = r;
    din = d;
    din_valid = v;
    frame_sync = s;
    @(posedge clk);
    #1;
    chk({tag, ".dout"}, dout, dq);
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(dv));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(se));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
  endtask
  initial begin
    step("rst0", 0, 8'hFF, 1, 1, 4'b0000, 0, 0, 0, 32'h00000000);
    step("rst1", 0, 8'h00, 0, 0, 4'b0000, 0, 0, 0, 32'h00000000);
    step("f1c0", 1, 8'hA0, 1, 1, 4'b0001, 0, 0, 1, 32'h000000A0);
    step("f1c1", 1, 8'h11, 1, 0, 4'b0010, 0, 0, 1, 32'h000011A0);
    step("f1c2", 1, 8'h22, 1, 0, 4'b0100, 0, 0, 1, 32'h002211A0);
    step("f1c3", 1, 8'h33, 1, 0, 4'b1000, 1, 0, 1, 32'h332211A0);
    step("idle", 1, 8'hEE, 0, 0, 4'b0000, 0, 0, 1, 32'h332211A0);
    step("miss44", 1, 8'h44, 1, 0, 4'b0000, 0, 1, 0, 32'h332211A0);
    step("hunt55", 1, 8'h55, 1, 0, 4'b0000, 0, 0, 0, 32'h332211A0);
    step("hunt66", 1, 8'h66, 1, 0, 4'b0000, 0, 0, 0, 32'h332211A0);
    step("lock77", 1, 8'h77, 1, 1, 4'b0001, 0, 0, 1, 32'h33221177);
    step("f2c1", 1, 8'h20, 1, 0, 4'b0010, 0, 0, 1, 32'h33222077);
    step("f2c2", 1, 8'h30, 1, 0, 4'b0100, 0, 0, 1, 32'h33302077);
    step("f2c3", 1, 8'h40, 1, 0, 4'b1000, 1, 0, 1, 32'h40302077);
    step("f3c0", 1, 8'h10, 1, 1, 4'b0001, 0, 0, 1, 32'h40302010);
    step("f3c1", 1, 8'h21, 1, 0, 4'b0010, 0, 0, 1, 32'h40302110);
    step("early99", 1, 8'h99, 1, 1, 4'b0001, 0, 1, 1, 32'h40302199);
    step("f4c1", 1, 8'hA1, 1, 0, 4'b0010, 0, 0, 1, 32'h4030A199);
    step("f4c2", 1, 8'hB2, 1, 0, 4'b0100, 0, 0, 1, 32'h40B2A199);
    step("f4c3", 1, 8'hC3, 1, 0, 4'b1000, 1, 0, 1, 32'hC3B2A199);
    step("miss44b", 1, 8'h44, 1, 0, 4'b0000, 0, 1, 0, 32'hC3B2A199);
    step("relock88", 1, 8'h88, 1, 1, 4'b0001, 0, 0, 1, 32'hC3B2A188);
    step("f5c1", 1, 8'hD1, 1, 0, 4'b0010, 0, 0, 1, 32'hC3B2D188);
    step("f5c2", 1, 8'hD2, 1, 0, 4'b0100, 0, 0, 1, 32'hC3D2D188);
    step("f5c3", 1, 8'hD3, 1, 0, 4'b1000, 1, 0, 1, 32'hD3D2D188);
    step("gapc0", 1, 8'hE0, 1, 1, 4'b0001, 0, 0, 1, 32'hD3D2D1E0);
    step("gapi0", 1, 8'h5A, 0, 1, 4'b0000, 0, 0, 1, 32'hD3D2D1E0);
    step("gapi1", 1, 8'h5B, 0, 1, 4'b0000, 0, 0, 1, 32'hD3D2D1E0);
    step("gapc1", 1, 8'hE1, 1, 0, 4'b0010, 0, 0, 1, 32'hD3D2E1E0);
    step("gapi2", 1, 8'h5C, 0, 1, 4'b0000, 0, 0, 1, 32'hD3D2E1E0);
    step("gapi3", 1, 8'h5D, 0, 1, 4'b0000, 0, 0, 1, 32'hD3D2E1E0);
    step("gapc2", 1, 8'hE2, 1, 0, 4'b0100, 0, 0, 1, 32'hD3E2E1E0);
    step("gapi4", 1, 8'h5E, 0, 1, 4'b0000, 0, 0, 1, 32'hD3E2E1E0);
    step("gapc3", 1, 8'hE3, 1, 0, 4'b1000, 1, 0, 1, 32'hE3E2E1E0);
    step("rmc0", 1, 8'hF0, 1, 1, 4'b0001, 0, 0, 1, 32'hE3E2E1F0);
    step("rmc1", 1, 8'hF1, 1, 0, 4'b0010, 0, 0, 1, 32'hE3E2F1F0);
    step("rstmid", 0, 8'hF2, 1, 0, 4'b0000, 0, 0, 0, 32'h00000000);
    step("postrst", 1, 8'h12, 1, 0, 4'b0000, 0, 0, 0, 32'h00000000);
    step("relock34", 1, 8'h34, 1, 1, 4'b0001, 0, 0, 1, 32'h00000034);
    step("tail", 1, 8'h00, 0, 0, 4'b0000, 0, 0, 1, 32'h00000034);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
